fifo_reader: RTL and testbench
==============================

# fifo_reader

Drains the synchronous FIFO from its read side and presents the words on a downstream valid/ready stream. Absorbs the FIFO's one-cycle read latency with a 2-entry skid buffer, so back-to-back transfers run at one word per cycle. Supports a synchronous flush and a sticky error flag. Sits between the FIFO read port and any stream consumer.

## Interface
- FIFO_WIDTH, 16, data word width; must match the FIFO.
- COUNT_W, 16, width of the transfer counter (only with FIFO_READER_STATS_EN).
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- data_out  input  FIFO_WIDTH  FIFO read data; updated at the edge that samples rd_en=1, empty=0.
- empty  input  1  FIFO empty flag.
- underflow  input  1  FIFO underflow flag.
- rd_en  output  1  FIFO read request.
- m_data  output  FIFO_WIDTH  downstream data; head of skid buffer.
- m_valid  output  1  m_data valid.
- m_ready  input  1  downstream accept.
- flush  input  1  single-cycle request to discard buffered and in-flight data.
- flush_busy  output  1  high while in FLUSH state.
- err  output  1  sticky; set when underflow is seen.
- rd_count  output  COUNT_W  accepted-transfer count (only with FIFO_READER_STATS_EN).

## Operation
- State machine: RUN, FLUSH. Reset goes to RUN.
- Read fire: rd_fire = rd_en && !empty. rd_fire sets the inflight register for exactly one cycle.
- rd_en is combinational: (state==RUN) && !empty && !flush && (count + inflight − pop) < 2.
  - pop = m_valid && m_ready.
  - count is skid occupancy, 0..2.
- Capture: at the edge where inflight=1 and state==RUN, data_out is written to the skid tail.
- Pop and capture in the same cycle are both applied: count is unchanged and order is preserved.
- m_valid = (count != 0). m_data = head entry. Both are stable while m_valid && !m_ready (AXI-style hold).
- The buffer can never overflow, because the credit rule guarantees count + inflight ≤ 2.
- RUN→FLUSH when flush=1:
  - At that edge, count clears to 0.
  - No rd_en is issued while flush=1 or while in FLUSH.
  - If inflight=1, the arriving word is discarded.
- FLUSH→RUN at the first edge where inflight=0.
  - FLUSH lasts 1 cycle if a word was in flight, otherwise 0 cycles. In the 0-cycle case the block stays in RUN with an empty buffer.
- flush while m_valid && m_ready: the handshake completes. The flush then discards the remaining entries.
- err is set when underflow=1 at any edge and is cleared only by reset. Reading never depends on err.
- Reset mid-operation:
  - count, inflight and err clear to 0; state goes to RUN.
  - Buffered and in-flight data are lost.
  - The FIFO is reset by the same rst_n.
- Reset values: rd_en=0 (rst_n low forces rd_en=0), m_valid=0, m_data=0, flush_busy=0, err=0, rd_count=0.

## Timing
- Read latency: rd_en=1 with empty=0 in cycle N gives m_valid=1 in cycle N+2.
- Throughput: with m_ready held high and the FIFO non-empty, rd_en stays high and m_valid stays high from N+2 onward. That is one word per cycle.
- Backpressure: when m_ready drops, rd_en deasserts once count + inflight reaches 2 after pop. At most 2 words are buffered.
- Empty toggling: rd_en follows !empty in the same cycle. There are no bubbles beyond the FIFO's own empty cycles.
- flush_busy is registered. It is high in the cycle after flush only if a word was in flight.

## Configuration
- FIFO_READER_STATS_EN defined:
  - Adds the rd_count port.
  - rd_count increments on each pop and saturates at all-ones.
  - rd_count resets to 0. flush does not clear it.
- FIFO_READER_STATS_EN undefined:
  - The rd_count port and its counter are absent.
  - All other behaviour is identical.

## Structure
- Package fifo_reader_pkg holds:
  - state enum (RUN, FLUSH);
  - SKID_DEPTH = 2;
  - the skid count width localparam.
- Sub-module fifo_reader_skid: a 2-entry buffer with push, pop, clear, head data and count. Top-level fifo_reader owns the FSM, credit logic, err and stats.

## Test plan
- Reset with FIFO holding 3 words, then release with m_ready=1 → rd_en high on the first post-reset cycle, first m_valid 2 cycles later, words 0xA001..0xA003 appear in order on consecutive cycles.
- Stream 8 words with m_ready=1 → m_valid is continuous for 8 cycles, no gaps, no duplicates.
- Hold m_ready=0 with FIFO full → exactly 2 rd_en pulses, then rd_en=0. When m_ready is raised, the 2 buffered words are delivered first, in order.
- Pulse flush one cycle after rd_en, with 1 word in flight and 1 buffered → flush_busy=1 for 1 cycle, both words dropped, next m_data is the following FIFO word.
- Force underflow=1 for one cycle → err=1 and stays 1 until rst_n=0. rd_count (stats build) is unaffected.
- Stats build: 0xFFFF accepted transfers with COUNT_W=16 → rd_count holds 0xFFFF on further transfers. Assert rst_n=0 mid-stream → rd_count=0, m_valid=0 at the next edge.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared types and sizing for the FIFO read-side drainer.
package fifo_reader_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: 2-entry in-order skid buffer. slot0 is always the head;
// a pop shifts slot1 forward, a push lands at the first free slot after the
// pop has been accounted for, so pop+push in one cycle keeps order.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int FIFO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [FIFO_WIDTH-1:0] din,
  output logic [FIFO_WIDTH-1:0] head,
  output logic [SKID_CNT_W-1:0] count
);

  logic [FIFO_WIDTH-1:0] slot0;
  logic [FIFO_WIDTH-1:0] slot1;
  logic [SKID_CNT_W-1:0] wr_idx;
  logic [SKID_CNT_W-1:0] push_w;
  logic [SKID_CNT_W-1:0] pop_w;

  assign push_w = {{(SKID_CNT_W-1){1'b0}}, push};
  assign pop_w  = {{(SKID_CNT_W-1){1'b0}}, pop};
  assign wr_idx = count - pop_w;
  assign head   = slot0;

  // Occupancy and head slot; head is cleared on reset so m_data starts at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      slot0 <= '0;
    end else if (clr) begin
      count <= '0;
    end else begin
      count <= count + push_w - pop_w;
      if (pop) begin
        slot0 <= slot1;
      end
      if (push && (wr_idx == '0)) begin
        slot0 <= din;
      end
    end
  end

  // Second slot carries data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!clr && push && (wr_idx != '0)) begin
      slot1 <= din;
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains a synchronous FIFO (1-cycle read latency) onto a
// valid/ready stream at one word per cycle, using a 2-entry skid buffer and
// a credit check so the buffer can never overflow. Supports flush and a
// sticky underflow error flag.
// Optional build macro FIFO_READER_STATS_EN adds a saturating rd_count of
// accepted transfers.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int FIFO_WIDTH = 16
`ifdef FIFO_READER_STATS_EN
  , parameter int COUNT_W  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  empty,
  input  logic                  underflow,
  output logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic                  flush_busy,
  output logic                  err
`ifdef FIFO_READER_STATS_EN
  , output logic [COUNT_W-1:0]  rd_count
`endif
);

  state_t                state;
  logic                  inflight;
  logic                  pop;
  logic                  push;
  logic                  clr;
  logic                  rd_fire;
  logic [SKID_CNT_W-1:0] count;
  logic [SKID_CNT_W:0]   credit;

  // Words already committed (buffered + in flight) after this cycle's pop;
  // a new read is only issued while that stays below the buffer depth.
  assign pop     = m_valid && m_ready;
  assign credit  = {1'b0, count} + {{SKID_CNT_W{1'b0}}, inflight}
                 - {{SKID_CNT_W{1'b0}}, pop};
  assign rd_en   = rst_n && (state == RUN) && !empty && !flush
                 && (credit < SKID_DEPTH[SKID_CNT_W:0]);
  assign rd_fire = rd_en && !empty;

  // The word returning from the FIFO is dropped if a flush lands on it.
  assign push    = inflight && (state == RUN) && !flush;
  assign clr     = (state == RUN) && flush;
  assign m_valid = (count != '0);

  fifo_reader_skid #(
    .FIFO_WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (data_out),
    .head  (m_data),
    .count (count)
  );

  // Control FSM: tracks the in-flight read and waits it out after a flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      inflight   <= 1'b0;
      flush_busy <= 1'b0;
    end else begin
      inflight <= rd_fire;
      case (state)
        RUN: begin
          if (flush && inflight) begin
            state      <= FLUSH;
            flush_busy <= 1'b1;
          end
        end
        FLUSH: begin
          if (!inflight) begin
            state      <= RUN;
            flush_busy <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          flush_busy <= 1'b0;
        end
      endcase
    end
  end

  // Sticky underflow flag; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (underflow) begin
      err <= 1'b1;
    end
  end

`ifdef FIFO_READER_STATS_EN
  // Saturating count of accepted downstream transfers; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_count <= '0;
    end else if (pop && (rd_count != {COUNT_W{1'b1}})) begin
      rd_count <= rd_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: scoreboard bench for fifo_reader. A behavioural FIFO feeds
// the DUT; every word it hands out is pushed to an expected queue, which the
// negedge monitor drains on each downstream handshake and clears on flush or
// reset. Build with FIFO_READER_STATS_EN to also cover rd_count.
module tb_fifo_reader;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] data_out = '0;
  logic         empty = 1'b1;
  logic         underflow;
  logic         rd_en;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready;
  logic         flush;
  logic         flush_busy;
  logic         err;
`ifdef FIFO_READER_STATS_EN
  logic [15:0]  rd_count;
`endif

  logic         wr_en;
  logic [W-1:0] wr_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_reader #(
    .FIFO_WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_out   (data_out),
    .empty      (empty),
    .underflow  (underflow),
    .rd_en      (rd_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .flush      (flush),
    .flush_busy (flush_busy),
    .err        (err)
`ifdef FIFO_READER_STATS_EN
    , .rd_count (rd_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural FIFO: read data appears at the edge that accepts the read.
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  int fires = 0;
  always @(posedge clk) begin
    if (rst_n && rd_en && !empty) begin
      data_out <= fq[0];
      exp_q.push_back(fq[0]);
      void'(fq.pop_front());
      fires++;
    end
    if (wr_en) fq.push_back(wr_data);
    empty <= (fq.size() == 0);
  end

  // Reference model + monitor, evaluated mid-cycle.
  bit        chk_en = 0;
  int        fired_prev = 0;
  bit        busy_exp = 0;
  bit        err_exp = 0;
  int        hs = 0;
  logic [15:0] cnt_exp = '0;
  always @(negedge clk) begin
    int outst;
    bit mv, pop, rd_x;
    outst = exp_q.size();
    mv    = (outst - fired_prev) > 0;
    pop   = mv && m_ready;
    rd_x  = rst_n && !busy_exp && !empty && !flush && ((outst - int'(pop)) < 2);
    if (chk_en) begin
      check("m_valid", m_valid, mv);
      check("rd_en", rd_en, rd_x);
      check("flush_busy", flush_busy, busy_exp);
      check("err", err, err_exp);
`ifdef FIFO_READER_STATS_EN
      check("rd_count", rd_count, cnt_exp);
`endif
      if (pop) check("m_data", m_data, exp_q[0]);
    end
    if (!rst_n) begin
      exp_q.delete();
      fired_prev = 0;
      busy_exp   = 0;
      err_exp    = 0;
      cnt_exp    = '0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        hs++;
        if (cnt_exp != 16'hFFFF) cnt_exp++;
      end
      busy_exp = flush && (fired_prev != 0);
      if (flush) exp_q.delete();
      fired_prev = rd_x ? 1 : 0;
      err_exp    = err_exp | underflow;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [W-1:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    int h0, f0, run, longest, vcnt;
    rst_n = 1'b0; m_ready = 1'b0; flush = 1'b0; underflow = 1'b0;
    wr_en = 1'b0; wr_data = '0;
    step(); step();
    chk_en = 1;

    // Reset state
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 16'h0000);
    check("rst_flush_busy", flush_busy, 1'b0);
    check("rst_err", err, 1'b0);

    // Preload three words during reset, then release with m_ready high
    put(16'hA001); put(16'hA002); put(16'hA003);
    m_ready = 1'b1;
    rst_n   = 1'b1;
    #1;
    check("first_rd_en", rd_en, 1'b1);
    h0 = hs;
    step(); step(); step();
    check("lat_first_word", hs - h0, 1);
    step(); step();
    check("lat_three_words", hs - h0, 3);

    // Stream of 8 words with m_ready held high
    run = 0; longest = 0; vcnt = 0; h0 = hs;
    for (int i = 0; i < 20; i++) begin
      wr_en   = (i < 8);
      wr_data = 16'hB000 + 16'(i);
      step();
      if (m_valid) begin vcnt++; run++; if (run > longest) longest = run; end
      else run = 0;
    end
    wr_en = 1'b0;
    check("stream_valid_cycles", vcnt, 8);
    check("stream_longest_run", longest, 8);
    check("stream_handshakes", hs - h0, 8);

    // Backpressure: only two reads may be outstanding
    m_ready = 1'b0;
    f0 = fires; h0 = hs;
    for (int i = 0; i < 5; i++) put(16'hC001 + 16'(i));
    for (int i = 0; i < 6; i++) step();
    check("bp_read_pulses", fires - f0, 2);
    check("bp_rd_en_low", rd_en, 1'b0);
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("bp_drained", hs - h0, 5);

    // Flush with one word buffered and one in flight
    m_ready = 1'b0;
    h0 = hs;
    put(16'hD001);
    step(); step(); step();
    put(16'hD002);
    check("fl_rd_en", rd_en, 1'b1);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_busy_high", flush_busy, 1'b1);
    check("fl_valid_low", m_valid, 1'b0);
    step();
    check("fl_busy_low", flush_busy, 1'b0);
    put(16'hD003);
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("fl_only_next_word", hs - h0, 1);

    // Underflow sets a sticky error
    underflow = 1'b1;
    step();
    underflow = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("err_sticky", err, 1'b1);

    // Reset in the middle of a stream
    for (int i = 0; i < 6; i++) put(16'hE000 + 16'(i));
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", m_valid, 1'b0);
    check("mid_rst_err", err, 1'b0);
`ifdef FIFO_READER_STATS_EN
    check("mid_rst_count", rd_count, 16'h0000);
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      wr_en     = ($urandom % 10) < 6;
      wr_data   = 16'($urandom);
      m_ready   = ($urandom % 10) < 7;
      flush     = ($urandom % 40) == 0;
      underflow = ($urandom % 150) == 0;
      rst_n     = ($urandom % 200) != 0;
      step();
    end
    wr_en = 1'b0; flush = 1'b0; underflow = 1'b0; rst_n = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();

`ifdef FIFO_READER_STATS_EN
    // Saturation of the transfer counter
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < 65545; i++) begin
      wr_data = 16'(i);
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("count_saturated", rd_count, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
